// File: rtl/mips_prog_loader.sv
// Byte-stream program loader: frames -> big-endian words -> memory writes,
// holding the core until a frame checksums good, then releasing it at BASE.
module mips_prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic [31:0]       cpu_pc,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    S_SYNC,
    S_ADDR_HI,
    S_ADDR_LO,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CHK,
    S_START,
    S_ERR
  } state_t;

  localparam logic [16:0] LIM = 17'(2 ** ADDR_W);

  state_t            state_q;
  logic [15:0]       base_q;
  logic [15:0]       cnt_q;
  logic [15:0]       widx_q;
  logic [1:0]        bcnt_q;
  logic [23:0]       word_q;
  logic [7:0]        xor_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              cpu_hold_q;
  logic              cpu_start_q;
  logic [31:0]       cpu_pc_q;
  logic              done_q;
  logic              err_q;

  logic              acc;
  logic [15:0]       cnt_d;
  logic [16:0]       end_d;
  logic              range_bad;
  logic [31:0]       word_d;
  logic [ADDR_W-1:0] addr_d;

  assign acc       = in_valid & in_ready;
  assign cnt_d     = {cnt_q[15:8], in_data};
  // 17-bit sum so a frame running past the top of memory cannot wrap
  assign end_d     = {1'b0, base_q} + {1'b0, cnt_d};
  assign range_bad = ({1'b0, base_q} >= LIM) || (end_d > LIM);
  assign word_d    = {word_q, in_data};
  assign addr_d    = base_q[ADDR_W-1:0] + widx_q[ADDR_W-1:0];

  assign in_ready  = ~reset & (state_q != S_START) & (state_q != S_ERR);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign cpu_start = cpu_start_q;
  assign cpu_pc    = cpu_pc_q;
  assign done      = done_q;
  assign err       = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_SYNC;
      base_q      <= '0;
      cnt_q       <= '0;
      widx_q      <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      xor_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      cpu_start_q <= 1'b0;
      cpu_pc_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q    <= 1'b0;
      cpu_start_q <= 1'b0;
      unique case (state_q)
        S_SYNC: if (acc && in_data == 8'hA5) begin
          state_q    <= S_ADDR_HI;
          cpu_hold_q <= 1'b1;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          xor_q      <= '0;
          widx_q     <= '0;
          bcnt_q     <= '0;
        end
        S_ADDR_HI: if (acc) begin
          base_q[15:8] <= in_data;
          state_q      <= S_ADDR_LO;
        end
        S_ADDR_LO: if (acc) begin
          base_q[7:0] <= in_data;
          state_q     <= S_CNT_HI;
        end
        S_CNT_HI: if (acc) begin
          cnt_q[15:8] <= in_data;
          state_q     <= S_CNT_LO;
        end
        S_CNT_LO: if (acc) begin
          cnt_q <= cnt_d;
          if (range_bad) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else if (cnt_d == 16'd0) begin
            state_q <= S_CHK;
          end else begin
            state_q <= S_DATA;
          end
        end
        S_DATA: if (acc) begin
          word_q <= word_d[23:0];
          bcnt_q <= bcnt_q + 2'd1;
          xor_q  <= xor_q ^ in_data;
          if (bcnt_q == 2'd3) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= word_d;
            widx_q      <= widx_q + 16'd1;
            if (widx_q + 16'd1 == cnt_q) state_q <= S_CHK;
          end
        end
        S_CHK: if (acc) begin
          if (in_data == xor_q) begin
            state_q     <= S_START;
            cpu_start_q <= 1'b1;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b1;
            cpu_pc_q    <= {16'd0, base_q};
          end else begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end
        end
        S_START: state_q <= S_SYNC;
        S_ERR:   state_q <= S_SYNC;
        default: state_q <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Randomized bench for mips_prog_loader against a frame-level
// reference model of expected writes and release/reject outcome.
module tb_mips_prog_loader;

  localparam int AW  = 10;
  localparam int DEP = 1 << AW;

  typedef logic [7:0] bq_t[$];
  typedef logic [AW+31:0] wq_t[$];

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          cpu_start;
  logic [31:0]   cpu_pc;
  logic          done;
  logic          err;

  mips_prog_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .cpu_start(cpu_start), .cpu_pc(cpu_pc),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  wq_t         obs;
  int          starts = 0;
  int          wr_at_start = -1;
  logic [31:0] tbmem [DEP];

  always @(negedge clk) begin
    if (mem_we) begin
      obs.push_back({mem_addr, mem_wdata});
      tbmem[mem_addr] = mem_wdata;
    end
    if (cpu_start) begin
      starts++;
      wr_at_start = obs.size();
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("rdy_timeout", 64'(n), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic model(input bq_t q, output wq_t ew, output bit es,
                       output bit ee, output logic [15:0] eb);
    int i = 0;
    int base, cnt;
    logic [7:0]  x = 8'h00;
    logic [31:0] w;
    ew = {};
    es = 0;
    ee = 0;
    while (i < q.size() && q[i] != 8'hA5) i++;
    base = int'({q[i+1], q[i+2]});
    cnt  = int'({q[i+3], q[i+4]});
    eb   = 16'(base);
    if (base >= DEP || base + cnt > DEP) begin
      ee = 1;
      return;
    end
    for (int k = 0; k < cnt; k++) begin
      w = {q[i+5+4*k], q[i+6+4*k], q[i+7+4*k], q[i+8+4*k]};
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      ew.push_back({AW'(base + k), w});
    end
    if (q[i+5+4*cnt] == x) es = 1;
    else ee = 1;
  endtask

  task automatic run_frame(input bq_t q, input int maxgap,
                           input string tag);
    wq_t         ew;
    bit          es, ee;
    logic [15:0] eb;
    model(q, ew, es, ee, eb);
    obs.delete();
    starts = 0;
    wr_at_start = -1;
    foreach (q[j]) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
      send_byte(q[j]);
    end
    chk({tag, "_rdy_now"}, 64'(in_ready), 64'(!(es || ee)));
    chk({tag, "_start_now"}, 64'(cpu_start), 64'(es));
    chk({tag, "_err_now"}, 64'(err), 64'(ee));
    repeat (3) @(negedge clk);
    chk({tag, "_nwr"}, 64'(obs.size()), 64'(ew.size()));
    for (int k = 0; k < ew.size(); k++)
      if (k < obs.size()) chk({tag, "_wr"}, 64'(obs[k]), 64'(ew[k]));
    chk({tag, "_starts"}, 64'(starts), 64'(es));
    chk({tag, "_done"}, 64'(done), 64'(es));
    chk({tag, "_err"}, 64'(err), 64'(ee));
    chk({tag, "_hold"}, 64'(cpu_hold), 64'(!es));
    if (es) begin
      chk({tag, "_pc"}, 64'(cpu_pc), 64'({16'd0, eb}));
      chk({tag, "_order"}, 64'(wr_at_start), 64'(ew.size()));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"}, 64'(in_ready), 64'd0);
    chk({tag, "_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_hold"}, 64'(cpu_hold), 64'd1);
    chk({tag, "_start"}, 64'(cpu_start), 64'd0);
    chk({tag, "_pc"}, 64'(cpu_pc), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    bq_t good, bad, q;
    int  base, cnt;
    logic [7:0] x;

    good = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h28, 8'h09, 8'h00,
             8'hC8, 8'h00, 8'h00, 8'h08, 8'h00, 8'hE1};
    bad = good;
    bad[13] = 8'hE0;

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdy_after", 64'(in_ready), 64'd1);

    run_frame(good, 0, "good");
    chk("good_mem0", 64'(tbmem[0]), 64'h280900C8);
    chk("good_mem1", 64'(tbmem[1]), 64'h00000800);
    run_frame(good, 3, "gaps");
    run_frame(bad, 0, "badchk");
    run_frame(good, 1, "recover");
    run_frame('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00},
              0, "zero");

    run_frame('{8'hA5, 8'h03, 8'hFF, 8'h00, 8'h02}, 0, "ovf");
    obs.delete();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (2) @(negedge clk);
    chk("ovf_drop_nwr", 64'(obs.size()), 64'd0);
    chk("ovf_drop_err", 64'(err), 64'd1);
    chk("ovf_drop_hold", 64'(cpu_hold), 64'd1);
    run_frame('{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00}, 0, "base_top");
    run_frame('{8'hA5, 8'h03, 8'hFE, 8'h00, 8'h01,
                8'h12, 8'h34, 8'h56, 8'h78, 8'h08}, 0, "fit_edge");

    foreach (good[j]) if (j < 11) send_byte(good[j]);
    #2 reset = 1'b1;
    #1 check_reset_vals("midrst");
    chk("midrst_mem0", 64'(tbmem[0]), 64'h280900C8);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_frame(good, 0, "postrst");

    for (int f = 0; f < 12; f++) begin
      base = $urandom_range(0, DEP + 40);
      if (f == 0) base = DEP - 2;
      cnt = $urandom_range(0, 5);
      q = '{8'hA5, 8'(base >> 8), 8'(base), 8'(cnt >> 8), 8'(cnt)};
      if (base < DEP && base + cnt <= DEP) begin
        x = 8'h00;
        for (int k = 0; k < 4 * cnt; k++) begin
          q.push_back(8'($urandom));
          x ^= q[q.size()-1];
        end
        if ($urandom_range(0, 3) == 0) x = ~x;
        q.push_back(x);
      end
      run_frame(q, 2, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
